// File: rtl/aes_package.sv
// Shared types and constants for the AES stream engine.
//   aes_eng_state_t : engine FSM states
//   ctrl_engine_t   : controller -> engine {clear, start, enable}
//   flags_engine_t  : engine -> controller {done, busy, blk_cnt}
package aes_package;

  localparam int unsigned AES_DATA_W  = 32;
  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CIPHER,
    DRAIN,
    DONE
  } aes_eng_state_t;

  typedef struct packed {
    logic clear;
    logic start;
    logic enable;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 done;
    logic                 busy;
    logic [AES_CNT_W-1:0] blk_cnt;
  } flags_engine_t;

endpackage

// File: rtl/aes_word_buffer.sv
// Block-wide register viewed as DATA_W words with a wrapping word index.
// Used for packing plaintext (word writes) and unpacking results (block load + word reads).
//   clk, reset : clock, async active-high reset
//   clear      : sync clear of contents and index
//   wr_en/wr_data : write word at current index, then advance index
//   ld_en/ld_block: load the whole block, index back to word 0
//   adv        : advance index without writing
//   block      : full register contents (word 0 in LSBs)
//   rd_word    : word at current index
//   last       : current index is the final word of the block
module aes_word_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               ld_en,
  input  logic [BLOCK_W-1:0] ld_block,
  input  logic               adv,
  output logic [BLOCK_W-1:0] block,
  output logic [DATA_W-1:0]  rd_word,
  output logic               last
);

  localparam int unsigned WORDS = BLOCK_W / DATA_W;
  localparam int unsigned IDX_W = $clog2(WORDS);

  logic [WORDS-1:0][DATA_W-1:0] words_q;
  logic [IDX_W-1:0]             idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      words_q <= '0;
      idx_q   <= '0;
    end else if (ld_en) begin
      words_q <= ld_block;
      idx_q   <= '0;
    end else if (wr_en) begin
      words_q[idx_q] <= wr_data;
      idx_q          <= idx_q + IDX_W'(1);
    end else if (adv) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign block   = words_q;
  assign rd_word = words_q[idx_q];
  assign last    = (idx_q == IDX_W'(WORDS - 1));

endmodule

// File: rtl/aes_stream_engine.sv
// Engine side of the AES HWPE: packs plaintext words into blocks, hands each block to the
// cipher core over req/ack, and streams the result words back out.
//   clk, reset      : clock, async active-high reset
//   ctrl_i          : {clear, start, enable} from the controller FSM
//   nb_blocks_i     : block count of the job, sampled on an accepted start
//   flags_o         : {done, busy, blk_cnt} back to the controller
//   pt_valid_i/pt_ready_o/pt_data_i : plaintext word stream in
//   ct_valid_o/ct_ready_i/ct_data_o : ciphertext word stream out
//   core_req_o/core_state_o         : block request to the cipher core
//   core_ack_i/core_result_i        : one-cycle result pulse from the core
module aes_stream_engine
  import aes_package::*;
#(
  parameter int unsigned DATA_W  = AES_DATA_W,
  parameter int unsigned BLOCK_W = AES_BLOCK_W,
  parameter int unsigned CNT_W   = AES_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  ctrl_engine_t       ctrl_i,
  input  logic [CNT_W-1:0]   nb_blocks_i,
  output flags_engine_t      flags_o,
  input  logic               pt_valid_i,
  output logic               pt_ready_o,
  input  logic [DATA_W-1:0]  pt_data_i,
  output logic               ct_valid_o,
  input  logic               ct_ready_i,
  output logic [DATA_W-1:0]  ct_data_o,
  output logic               core_req_o,
  output logic [BLOCK_W-1:0] core_state_o,
  input  logic               core_ack_i,
  input  logic [BLOCK_W-1:0] core_result_i
);

  aes_eng_state_t   state_q;
  logic [CNT_W-1:0] nb_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_cnt_inc;
  logic             req_held_q;

  logic live;
  logic pt_fire;
  logic ct_fire;
  logic ack_take;
  logic pack_last;
  logic unpack_last;

  logic [BLOCK_W-1:0] pack_block;
  logic [BLOCK_W-1:0] unpack_block_unused;
  logic [DATA_W-1:0]  pack_word_unused;
  logic [DATA_W-1:0]  unpack_word;

  // Clear forces every output low in the same cycle it is asserted.
  assign live = ~ctrl_i.clear;

  assign pt_ready_o = live & (state_q == LOAD) & ctrl_i.enable;
  // A request already raised stays up even if enable drops; a new one needs enable.
  assign core_req_o = live & (state_q == CIPHER) & (ctrl_i.enable | req_held_q);
  assign ct_valid_o = live & (state_q == DRAIN);

  assign ct_data_o    = live ? unpack_word : '0;
  assign core_state_o = live ? pack_block : '0;

  assign pt_fire  = pt_valid_i & pt_ready_o;
  assign ct_fire  = ct_valid_o & ct_ready_i;
  assign ack_take = core_req_o & core_ack_i;

  assign blk_cnt_inc = blk_cnt_q + CNT_W'(1);

  always_comb begin
    flags_o = '0;
    if (live) begin
      flags_o.done    = (state_q == DONE);
      flags_o.busy    = (state_q != IDLE);
      flags_o.blk_cnt = AES_CNT_W'(blk_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      blk_cnt_q  <= '0;
      req_held_q <= 1'b0;
    end else if (ctrl_i.clear) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      blk_cnt_q  <= '0;
      req_held_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_i.start && ctrl_i.enable) begin
            nb_q       <= nb_blocks_i;
            blk_cnt_q  <= '0;
            req_held_q <= 1'b0;
            state_q    <= (nb_blocks_i == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (pt_fire && pack_last) state_q <= CIPHER;
        end
        CIPHER: begin
          if (ack_take) begin
            req_held_q <= 1'b0;
            state_q    <= DRAIN;
          end else if (core_req_o) begin
            req_held_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (ct_fire && unpack_last) begin
            blk_cnt_q <= blk_cnt_inc;
            state_q   <= (blk_cnt_inc == nb_q) ? DONE : LOAD;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  aes_word_buffer #(
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W)
  ) u_pack (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctrl_i.clear),
    .wr_en   (pt_fire),
    .wr_data (pt_data_i),
    .ld_en   (1'b0),
    .ld_block('0),
    .adv     (1'b0),
    .block   (pack_block),
    .rd_word (pack_word_unused),
    .last    (pack_last)
  );

  aes_word_buffer #(
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W)
  ) u_unpack (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctrl_i.clear),
    .wr_en   (1'b0),
    .wr_data ('0),
    .ld_en   (ack_take),
    .ld_block(core_result_i),
    .adv     (ct_fire),
    .block   (unpack_block_unused),
    .rd_word (unpack_word),
    .last    (unpack_last)
  );

endmodule
